// File: rtl/pcie_rx_snoop_filter.sv
// PCIe RX snoop filter: captures selected TLP classes into a 72-bit FIFO with zero-word gaps.
// Optional SNOOP_TIMESTAMP_EN appends a {8'hF0, timestamp} trailer word after each captured TLP.
module pcie_rx_snoop_filter #(
  parameter int GAP   = 7,
  parameter int GAP_W = 4
) (
  input  logic        clk,
  input  logic        sys_rst_n,
  input  logic [63:0] m_axis_rx_tdata,
  input  logic [7:0]  m_axis_rx_tkeep,
  input  logic        m_axis_rx_tlast,
  input  logic        m_axis_rx_tvalid,
  input  logic [21:0] m_axis_rx_tuser,
  output logic        m_axis_rx_tready,
  input  logic [3:0]  cfg_capture_mask,
  input  logic        cnt_clr,
  output logic [71:0] din,
  output logic        wr_en,
  input  logic        full,
  input  logic        prog_full,
  output logic [31:0] tlp_cnt,
  output logic [31:0] drop_cnt,
  output logic        overflow
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_DROP,
    S_TRAIL
  } state_t;

  state_t             r_state;
  logic [GAP_W-1:0]   r_gap;
  logic               w_acc;
  logic               w_sop;
  logic               w_cap;
  logic [3:0]         w_cls;
  logic [4:0]         w_type;
  logic               w_due;
  logic [71:0]        w_data;
  logic               w_gap_wr;
  logic               w_load;
  logic               w_unused;

`ifdef SNOOP_TIMESTAMP_EN
  logic [63:0]        r_ts;
  logic [63:0]        r_ts_lat;
`endif

  assign w_unused = ^m_axis_rx_tuser;
  assign w_type   = m_axis_rx_tdata[28:24];

`ifdef SNOOP_TIMESTAMP_EN
  assign m_axis_rx_tready = (r_state != S_TRAIL);
`else
  assign m_axis_rx_tready = 1'b1;
`endif

  assign w_acc = m_axis_rx_tvalid & m_axis_rx_tready;
  assign w_sop = w_acc & (r_state == S_IDLE);

  always_comb begin
    w_cls = 4'b0000;
    unique case (1'b1)
      (w_type == 5'b00000) && !m_axis_rx_tdata[30]: w_cls[0] = 1'b1;
      (w_type == 5'b00000) &&  m_axis_rx_tdata[30]: w_cls[1] = 1'b1;
      (w_type == 5'b01010):                         w_cls[2] = 1'b1;
      default:                                      w_cls[3] = 1'b1;
    endcase
  end

  assign w_cap    = (|(w_cls & cfg_capture_mask)) & ~prog_full;
  assign w_gap_wr = (r_state == S_IDLE) & ~w_acc & (r_gap != '0);

  always_comb begin
    w_due  = 1'b0;
    w_data = 72'h0;
    unique case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          w_due  = w_cap;
          w_data = {m_axis_rx_tkeep, m_axis_rx_tdata};
        end else if (r_gap != '0) begin
          w_due  = 1'b1;
        end
      end
      S_DATA: begin
        w_due  = w_acc;
        w_data = {m_axis_rx_tkeep, m_axis_rx_tdata};
      end
      S_TRAIL: begin
        w_due  = 1'b1;
`ifdef SNOOP_TIMESTAMP_EN
        w_data = {8'hF0, r_ts_lat};
`endif
      end
      default: ;
    endcase
  end

  // Gap reload marks the true end of a captured TLP (after trailer when present)
`ifdef SNOOP_TIMESTAMP_EN
  assign w_load = (r_state == S_TRAIL);
`else
  assign w_load = (w_sop & w_cap & m_axis_rx_tlast)
                | ((r_state == S_DATA) & w_acc & m_axis_rx_tlast);
`endif

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state  <= S_IDLE;
      r_gap    <= '0;
      wr_en    <= 1'b0;
      din      <= 72'h0;
      tlp_cnt  <= 32'h0;
      drop_cnt <= 32'h0;
      overflow <= 1'b0;
    end else begin
      wr_en <= w_due & ~full;
      if (w_due && !full)
        din <= w_data;

      if (cnt_clr)
        overflow <= 1'b0;
      else if (w_due && full)
        overflow <= 1'b1;

      if (cnt_clr)
        tlp_cnt <= 32'h0;
      else if (w_sop && w_cap && tlp_cnt != 32'hFFFF_FFFF)
        tlp_cnt <= tlp_cnt + 32'd1;

      if (cnt_clr)
        drop_cnt <= 32'h0;
      else if (w_sop && !w_cap && drop_cnt != 32'hFFFF_FFFF)
        drop_cnt <= drop_cnt + 32'd1;

      if (w_load)
        r_gap <= GAP_W'(GAP);
      else if (w_gap_wr && !full)
        r_gap <= r_gap - GAP_W'(1);

      unique case (r_state)
        S_IDLE: begin
          if (w_sop) begin
            if (w_cap) begin
`ifdef SNOOP_TIMESTAMP_EN
              r_state <= m_axis_rx_tlast ? S_TRAIL : S_DATA;
`else
              r_state <= m_axis_rx_tlast ? S_IDLE : S_DATA;
`endif
            end else begin
              r_state <= m_axis_rx_tlast ? S_IDLE : S_DROP;
            end
          end
        end
        S_DATA: begin
          if (w_acc && m_axis_rx_tlast) begin
`ifdef SNOOP_TIMESTAMP_EN
            r_state <= S_TRAIL;
`else
            r_state <= S_IDLE;
`endif
          end
        end
        S_DROP: begin
          if (w_acc && m_axis_rx_tlast)
            r_state <= S_IDLE;
        end
        S_TRAIL: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef SNOOP_TIMESTAMP_EN
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_ts     <= 64'h0;
      r_ts_lat <= 64'h0;
    end else begin
      r_ts <= r_ts + 64'd1;
      if (w_sop && w_cap)
        r_ts_lat <= r_ts;
    end
  end
`endif

endmodule
